// File: rtl/irq_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RUN
    } state_t;

    localparam logic [31:0] URET_INST  = 32'h00200073;
    localparam logic [6:0]  OPC_SYSTEM = 7'h73;

    // Flush counter width; large enough for FLUSH_CYC up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/irq_controller_mc_prio_enc.sv
// Combinational lowest-index-wins priority encoder (index 0 highest priority).
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller_mc.sv
// Multi-source interrupt controller: latches requests, arbitrates by fixed
// priority, stalls the pipeline for a flush window, redirects fetch to a
// per-source vector and returns to the saved PC on URET. One ISR at a time.
// Build option: define IRQ_LEVEL_EN for level-sensitive sources (pend mirrors
// irq_src directly); the default build latches rising edges.
module irq_controller_mc
    import irq_pkg::*;
#(
    parameter int              NUM_SRC    = 4,
    parameter int              PC_W       = 12,
    parameter int              FLUSH_CYC  = 5,
    parameter logic [PC_W-1:0] ISR_BASE   = 12'hF00,
    parameter logic [PC_W-1:0] VEC_STRIDE = 12'h040,
    localparam int             ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    PC,
    input  logic [31:0]        inst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    output logic               ISR_stall,
    output logic               sel_ISR,
    output logic               ret_ISR,
    output logic               ISR_running,
    output logic [PC_W-1:0]    isr_pc,
    output logic [PC_W-1:0]    save_PC,
    output logic [ID_W-1:0]    isr_id,
    output logic [NUM_SRC-1:0] irq_ack
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] eligible;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_idx;
    logic               take;
    logic               is_uret;
    logic [PC_W-1:0]    vec_pc;

`ifdef IRQ_LEVEL_EN
    // Level-sensitive sources: the device holds its line until serviced.
    assign pend = irq_src;
`else
    logic [NUM_SRC-1:0] src_q;

    // Edge latch: a new rising edge wins over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            src_q <= '0;
            pend  <= '0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~irq_ack) | (irq_src & ~src_q);
        end
    end
`endif

    // Disabled sources stay pending; they simply do not compete.
    assign eligible = pend & irq_en;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // URET is a SYSTEM-opcode instruction; other SYSTEM encodings (ECALL etc.) do not return.
    assign is_uret = (inst[6:0] == OPC_SYSTEM) && (inst[31:7] == URET_INST[31:7]);

    // Vector address wraps to PC_W bits by construction.
    assign vec_pc = ISR_BASE + PC_W'(enc_idx) * VEC_STRIDE;

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        take        = 1'b0;
        ISR_stall   = 1'b0;
        sel_ISR     = 1'b0;
        ret_ISR     = 1'b0;
        ISR_running = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    take    = 1'b1;
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                ISR_stall = 1'b1;
                if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
                    sel_ISR = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                ISR_running = 1'b1;
                if (is_uret) begin
                    ret_ISR = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus entry-time capture of return address, vector and id.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            save_PC <= '0;
            isr_pc  <= '0;
            isr_id  <= '0;
            irq_ack <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_ack <= take ? (NUM_SRC'(1) << enc_idx) : '0;
            if (take) begin
                save_PC <= PC;
                isr_pc  <= vec_pc;
                isr_id  <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller_mc.sv
// Directed self-checking bench for irq_controller_mc (default edge-latched build).
module tb_irq_controller_mc;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] URET  = 32'h00200073;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pc;
    logic [31:0] inst;
    logic [3:0]  irq_src;
    logic [3:0]  irq_en;
    logic        isr_stall, sel_isr, ret_isr, isr_running;
    logic [11:0] isr_pc, save_pc;
    logic [1:0]  isr_id;
    logic [3:0]  irq_ack;

    int total = 0;
    int bad   = 0;

    irq_controller_mc dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (pc),
        .inst        (inst),
        .irq_src     (irq_src),
        .irq_en      (irq_en),
        .ISR_stall   (isr_stall),
        .sel_ISR     (sel_isr),
        .ret_ISR     (ret_isr),
        .ISR_running (isr_running),
        .isr_pc      (isr_pc),
        .save_PC     (save_pc),
        .isr_id      (isr_id),
        .irq_ack     (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first stall cycle of an entry; walks flush, run and URET.
    task automatic service(input logic [1:0] id, input logic [11:0] vec,
                           input logic [3:0] src_at_ack);
        int n;
        int sels;
        check("entry_stall", {31'b0, isr_stall}, 1);
        check("isr_id", {30'b0, isr_id}, {30'b0, id});
        check("isr_pc", {20'b0, isr_pc}, {20'b0, vec});
        check("save_pc", {20'b0, save_pc}, {20'b0, pc});
        check("irq_ack", {28'b0, irq_ack}, 32'(4'b0001 << id));
        irq_src = src_at_ack;
        n = 0;
        sels = 0;
        while (isr_stall && n < 20) begin
            if (sel_isr) sels++;
            n++;
            step();
            if (n == 1) begin
                irq_src = 4'b0000;
                check("ack_pulse", {28'b0, irq_ack}, 0);
            end
        end
        check("stall_len", n, 5);
        check("sel_once", sels, 1);
        check("running", {31'b0, isr_running}, 1);
        check("sel_after", {31'b0, sel_isr}, 0);
        inst = ECALL;
        #1;
        check("ecall_ret", {31'b0, ret_isr}, 0);
        step();
        check("ecall_run", {31'b0, isr_running}, 1);
        inst = URET;
        #1;
        check("uret_ret", {31'b0, ret_isr}, 1);
        check("uret_sel", {31'b0, sel_isr}, 0);
        step();
        inst = NOP;
        #1;
        check("run_drop", {31'b0, isr_running}, 0);
        check("ret_pulse", {31'b0, ret_isr}, 0);
    endtask

    // Pulse irq_src for one sampled cycle; returns on the first stall cycle.
    task automatic pulse(input logic [3:0] src);
        irq_src = src;
        step();
        check("lat_1cyc", {31'b0, isr_stall}, 0);
        irq_src = 4'b0000;
        step();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        pc = 12'h123;
        inst = NOP;
        irq_src = 4'b0000;
        irq_en = 4'hF;
        step();
        step();
        rst = 1'b0;
        check("rst_outs", {isr_stall, sel_isr, ret_isr, isr_running, irq_ack, isr_id}, 0);
        check("rst_pcs", {8'b0, isr_pc, save_pc}, 0);

        // Single source 2.
        pulse(4'b0100);
        service(2'd2, 12'hF80, 4'b0000);
        step();
        check("idle_quiet", {31'b0, isr_stall}, 0);

        // Priority: sources 1 and 3 together; 3 follows right after URET.
        pc = 12'h2A4;
        pulse(4'b1010);
        service(2'd1, 12'hF40, 4'b0000);
        check("src3_wait", {31'b0, isr_stall}, 0);
        step();
        service(2'd3, 12'hFC0, 4'b0000);

        // Masking: source 0 latched while disabled, serviced once enabled.
        irq_en = 4'b1110;
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (isr_stall) cnt++;
        end
        check("masked_stall", cnt, 0);
        irq_en = 4'hF;
        step();
        service(2'd0, 12'hF00, 4'b0000);

        // Ack/edge collision on source 2: re-serviced after URET.
        pulse(4'b0100);
        service(2'd2, 12'hF80, 4'b0100);
        step();
        service(2'd2, 12'hF80, 4'b0000);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (isr_stall) cnt++;
        end
        check("coll_cleared", cnt, 0);

        // Reset on flush cycle 3, with source 3 latched during flush.
        pulse(4'b0001);
        irq_src = 4'b1000;
        step();
        irq_src = 4'b0000;
        step();
        check("flush3_stall", {31'b0, isr_stall}, 1);
        rst = 1'b1;
        step();
        check("mid_rst_outs", {isr_stall, sel_isr, ret_isr, isr_running, irq_ack, isr_id}, 0);
        check("mid_rst_pcs", {8'b0, isr_pc, save_pc}, 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (isr_stall || sel_isr || isr_running) cnt++;
        end
        check("pend_cleared", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller_mc.md
Name: irq_controller_mc

Overview:
- Multi-source successor to the single-line ISR controller for the pipelined RV32IMC core. Sits beside the PC module.
- Latches edge-triggered requests from NUM_SRC sources behind a per-source enable mask, and arbitrates by fixed priority (index 0 highest).
- Stalls the pipeline for a parametrised flush window, redirects fetch to a per-source vector, and returns to the saved PC on URET.
- No nesting: one ISR at a time.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- PC_W, 12, PC width.
- FLUSH_CYC, 5, stall cycles before redirect (1..15).
- ISR_BASE, 12'hF00, vector of source 0.
- VEC_STRIDE, 12'h040, spacing between vectors.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- PC  in  PC_W  current fetch PC from PC module.
- inst  in  32  instruction in decode, used to catch URET.
- irq_src  in  NUM_SRC  raw request lines.
- irq_en  in  NUM_SRC  per-source enable mask.
- ISR_stall  out  1  pipeline stall.
- sel_ISR  out  1  one-cycle pulse: PC mux takes isr_pc.
- ret_ISR  out  1  one-cycle pulse: PC mux takes save_PC.
- ISR_running  out  1  ISR body executing.
- isr_pc  out  PC_W  vector of the active source.
- save_PC  out  PC_W  return address.
- isr_id  out  clog2(NUM_SRC) (min 1)  active source index.
- irq_ack  out  NUM_SRC  one-hot one-cycle acknowledge.

Behaviour:
- Reset: all outputs 0, state IDLE, pending 0, edge registers 0, flush counter 0. Reset mid-operation abandons any ISR without asserting ret_ISR.
- Edge detection: pend[i] is set when irq_src[i]=1 and the previous-cycle sample was 0. pend[i] is cleared by irq_ack[i]. If set and clear hit the same cycle, set wins and the new event is kept.
- Masking: requests latch regardless of irq_en. A source is eligible when pend & irq_en. Disabling a pending source holds it pending.
- State IDLE:
  - If any source is eligible, take the lowest eligible index k.
  - Next cycle: save_PC<=PC, isr_id<=k, isr_pc<=ISR_BASE+k*VEC_STRIDE (truncated to PC_W), irq_ack[k]=1 for one cycle, go to FLUSH.
  - Latency from the irq_src edge to ISR_stall is 2 cycles.
- State FLUSH:
  - ISR_stall=1 and the counter increments.
  - When the counter reaches FLUSH_CYC-1, sel_ISR pulses for 1 cycle, the counter clears, and state goes to RUN.
  - ISR_stall is high for exactly FLUSH_CYC cycles.
- State RUN:
  - ISR_running=1, ISR_stall=0.
  - When inst==32'h00200073 (URET): ret_ISR pulses, ISR_running drops next cycle, state goes to IDLE.
  - Any other inst with opcode 7'h73 does not return.
- During FLUSH and RUN, new requests latch into pend but are not serviced. After return, IDLE re-arbitrates and may start the next ISR on the following cycle; there is no idle gap requirement.
- URET seen in IDLE or FLUSH is ignored.
- sel_ISR and ret_ISR are never high together.
- isr_id and isr_pc hold their values until the next entry.

Optional Feature:
- Macro: IRQ_LEVEL_EN.
- Defined: sources are level-sensitive. pend mirrors irq_src directly with no latch and no edge detect. irq_ack still pulses. The device must deassert before URET or the ISR re-enters.
- Undefined: edge-latched behaviour as above.

Decomposition:
- Package irq_pkg holds:
  - state enum {IDLE, FLUSH, RUN};
  - URET_INST = 32'h00200073;
  - OPC_SYSTEM = 7'h73.
- Sub-module irq_prio_enc (NUM_SRC parameter): combinational lowest-index priority encoder. Outputs valid and index.
- Vector arithmetic and the FSM stay in the top.

Test Plan:
- Single source: pulse irq_src[2] with irq_en=4'hF and PC=12'h123.
  - Expected: irq_ack=4'b0100, save_PC=12'h123, isr_pc=12'hF80.
  - ISR_stall high for 5 cycles, then a sel_ISR pulse.
  - inst=32'h00200073 gives a ret_ISR pulse and ISR_running falls.
- Priority: edges on sources 1 and 3 in the same cycle.
  - Expected: source 1 serviced first (isr_pc=12'hF40).
  - After URET, source 3 is serviced on the next IDLE cycle (isr_pc=12'hFC0).
- Masking: edge on source 0 with irq_en=0.
  - Expected: no stall.
  - Raising irq_en[0] 10 cycles later starts service 1 cycle after.
- Ack/edge collision: a new irq_src[2] edge in the same cycle as irq_ack[2].
  - Expected: pend[2] stays set and source 2 is re-serviced after URET.
- Reset mid-FLUSH: assert rst on flush cycle 3.
  - Expected: all outputs 0 next cycle, pend cleared, no sel_ISR.
- Non-URET SYSTEM: ECALL (32'h00000073) during RUN.
  - Expected: ISR_running stays 1 and no ret_ISR.
